// File: rtl/reset_sequencer.sv
// reset_sequencer: per-channel active-low peripheral resets with staggered trigger release,
// watchdog fault latch, instant-reset kill path, alive heartbeat and master trigger.
module reset_sequencer #(
   parameter int NUM_CH      = 4,
   parameter int RELEASE_GAP = 16,
   parameter int WD_TIMEOUT  = 1250000,
   parameter int ALIVE_LOW   = 12500000,
   parameter int ALIVE_HIGH  = 1250000,
   parameter int CNT_W       = 28
) (
   input  logic              clk,
   input  logic              peripheral_aresetn,
   input  logic [NUM_CH-1:0] ch_trig_mode,
   input  logic [NUM_CH-1:0] ch_kill_en,
   input  logic              trig_src_ext,
   input  logic              int_trig_en,
   input  logic              counter_trigger,
   input  logic              ext_trigger,
   input  logic              sata_trigger,
   input  logic              watchdog_en,
   input  logic              watchdog_in,
   input  logic              instant_reset_in,
   input  logic              fault_clear,
   output logic [NUM_CH-1:0] ch_aresetn,
   output logic              master_trigger,
   output logic              alive_signal,
   output logic              reset_ack,
   output logic [31:0]       sts
);
   localparam int GW     = RELEASE_GAP > 1 ? $clog2(RELEASE_GAP) : 1;
   localparam int PERIOD = ALIVE_LOW + ALIVE_HIGH;

   typedef enum logic [1:0] {IDLE, RELEASE, RUN, FAULT} state_t;
   state_t state, state_d;

   logic [1:0]        rst_sync, ext_s, sata_s, inst_s;
   logic [2:0]        wd_s;
   logic              trig_q, m1, fault, fault_d, timeout, kill_d;
   logic              ext_sync, sata_sync, inst_sync, wd_sync, wd_edge;
   logic [CNT_W-1:0]  wd_cnt, al_cnt;
   logic [2:0]        idx, idx_d;
   logic [GW-1:0]     gap, gap_d;
   logic [NUM_CH-1:0] slot, rel, rel_d, ch_d;

   assign ext_sync  = ext_s[1];
   assign sata_sync = sata_s[1];
   assign inst_sync = inst_s[1];
   assign wd_sync   = wd_s[1];
   assign wd_edge   = wd_s[2] ^ wd_s[1];

   always_comb begin
      timeout = watchdog_en & ~wd_edge & (wd_cnt == CNT_W'(WD_TIMEOUT - 1));
      fault_d = timeout | (fault & ~fault_clear);
      kill_d  = fault_d | inst_sync;
      state_d = state;
      idx_d   = idx;
      gap_d   = gap;
      if (fault_d)
         state_d = FAULT;
      else if (state == FAULT)
         state_d = (fault_clear & ~inst_sync) ? IDLE : FAULT;
      else if (inst_sync)
         state_d = IDLE;
      else if (state == IDLE) begin
         if (trig_q) begin
            state_d = RELEASE;
            idx_d   = '0;
            gap_d   = '0;
         end
      end else if (!trig_q)
         state_d = IDLE;
      else if (state == RELEASE) begin
         if (idx == 3'(NUM_CH - 1))
            state_d = RUN;
         else if (gap == GW'(RELEASE_GAP - 1)) begin
            idx_d = idx + 3'd1;
            gap_d = '0;
         end else
            gap_d = gap + GW'(1);
      end
   end

   // rel remembers which trigger-mode channels were released in their own slot this sequence
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) slot[i] = (state == RELEASE) && (idx == 3'(i));
      rel_d = (state == IDLE || state == FAULT) ? '0 : (rel | slot) & ch_trig_mode;
      ch_d  = {NUM_CH{rst_sync[0]}} & (~ch_trig_mode | rel_d) & ~(ch_kill_en & {NUM_CH{kill_d}});
   end

   always_ff @(posedge clk or negedge peripheral_aresetn) begin
      if (!peripheral_aresetn) begin
         rst_sync       <= '0;
         ext_s          <= '0;
         sata_s         <= '0;
         inst_s         <= '0;
         wd_s           <= '0;
         trig_q         <= 1'b0;
         m1             <= 1'b0;
         master_trigger <= 1'b0;
         fault          <= 1'b0;
         reset_ack      <= 1'b0;
         wd_cnt         <= '0;
         al_cnt         <= '0;
         alive_signal   <= 1'b0;
         state          <= IDLE;
         idx            <= '0;
         gap            <= '0;
         rel            <= '0;
         ch_aresetn     <= '0;
      end else begin
         rst_sync       <= {rst_sync[0], 1'b1};
         ext_s          <= {ext_s[0], ext_trigger};
         sata_s         <= {sata_s[0], sata_trigger};
         inst_s         <= {inst_s[0], instant_reset_in};
         wd_s           <= {wd_s[1:0], watchdog_in};
         trig_q         <= trig_src_ext ? (ext_sync | sata_sync) : (int_trig_en & counter_trigger);
         m1             <= int_trig_en & counter_trigger;
         master_trigger <= m1;
         fault          <= fault_d;
         reset_ack      <= kill_d;
         wd_cnt         <= (!watchdog_en || wd_edge) ? '0 : timeout ? wd_cnt : wd_cnt + CNT_W'(1);
         al_cnt         <= (al_cnt == CNT_W'(PERIOD - 1)) ? '0 : al_cnt + CNT_W'(1);
         alive_signal   <= al_cnt >= CNT_W'(ALIVE_LOW);
         state          <= state_d;
         idx            <= idx_d;
         gap            <= gap_d;
         rel            <= rel_d;
         ch_aresetn     <= ch_d;
      end
   end

   assign sts = {13'd0, idx, rst_sync[1], alive_signal, inst_sync, wd_sync, trig_q, fault, state, 8'(ch_aresetn)};
endmodule
